// File: rtl/dispatch_allocator.sv
// dispatch_allocator
//   In-order dispatch stage. Takes up to DISP_W decoded instructions per cycle,
//   steers each one to a free ALU issue register or to the single load/store
//   issue register, renames the destination to the owning unit tag and fixes
//   up read tags against earlier writers in the same group.
//
// Optional feature macro: ALLOC_RR_EN
//   defined   : ALU search starts at a round-robin pointer, wrapping upward
//   undefined : fixed lowest-index-first ALU priority, no pointer register
//
// Ports (vectors are slot/unit concatenated, index 0 in the LSBs)
//   clk, rst                  clock, async active-high reset
//   rdy                       global enable; low freezes all state
//   flush                     drop every issue register, accept nothing
//   in_valid .. in_datay      decoded instruction slots
//   in_ready                  combinational prefix mask of accepted slots
//   alu_* / alu_ready         ALU issue registers with valid/ready handshake
//   ls_* / ls_ready           load/store issue register with handshake
//   mw_en, mw_addr, mw_tag    registered register-status update per slot
`timescale 1ns/1ps

module dispatch_allocator #(
    parameter int DISP_W  = 2,
    parameter int ALU_CNT = 2,
    parameter int TAG_W   = 3,
    parameter int WORD_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,
    input  logic                        flush,
    input  logic [DISP_W-1:0]           in_valid,
    input  logic [8*DISP_W-1:0]         in_op,
    input  logic [WORD_W*DISP_W-1:0]    in_pc,
    input  logic [DISP_W-1:0]           in_en_ry,
    input  logic [DISP_W-1:0]           in_en_w,
    input  logic [5*DISP_W-1:0]         in_addrx,
    input  logic [5*DISP_W-1:0]         in_addry,
    input  logic [5*DISP_W-1:0]         in_addrw,
    input  logic [TAG_W*DISP_W-1:0]     in_tagx,
    input  logic [TAG_W*DISP_W-1:0]     in_tagy,
    input  logic [WORD_W*DISP_W-1:0]    in_datax,
    input  logic [WORD_W*DISP_W-1:0]    in_datay,
    output logic [DISP_W-1:0]           in_ready,
    output logic [ALU_CNT-1:0]          alu_valid,
    input  logic [ALU_CNT-1:0]          alu_ready,
    output logic [4*ALU_CNT-1:0]        alu_op,
    output logic [WORD_W*ALU_CNT-1:0]   alu_pc,
    output logic [TAG_W*ALU_CNT-1:0]    alu_tagx,
    output logic [TAG_W*ALU_CNT-1:0]    alu_tagy,
    output logic [TAG_W*ALU_CNT-1:0]    alu_tagw,
    output logic [WORD_W*ALU_CNT-1:0]   alu_datax,
    output logic [WORD_W*ALU_CNT-1:0]   alu_datay,
    output logic [5*ALU_CNT-1:0]        alu_addrw,
    output logic                        ls_valid,
    input  logic                        ls_ready,
    output logic [3:0]                  ls_op,
    output logic [WORD_W-1:0]           ls_pc,
    output logic [TAG_W-1:0]            ls_tagx,
    output logic [TAG_W-1:0]            ls_tagy,
    output logic [TAG_W-1:0]            ls_tagw,
    output logic [WORD_W-1:0]           ls_datax,
    output logic [WORD_W-1:0]           ls_datay,
    output logic [4:0]                  ls_addrw,
    output logic [DISP_W-1:0]           mw_en,
    output logic [5*DISP_W-1:0]         mw_addr,
    output logic [TAG_W*DISP_W-1:0]     mw_tag
);

    logic [ALU_CNT-1:0] alu_free, alu_claim;
    int                 alu_src [ALU_CNT];
    logic               ls_free, ls_claim;
    int                 ls_src;
    logic [DISP_W-1:0]  acc, wr;
    logic [TAG_W-1:0]   own_tag [DISP_W];
    logic [TAG_W-1:0]   s_tagx  [DISP_W];
    logic [TAG_W-1:0]   s_tagy  [DISP_W];
    logic [TAG_W-1:0]   s_tagw  [DISP_W];
    logic [WORD_W-1:0]  s_datay [DISP_W];
    logic [4:0]         s_addrw [DISP_W];
    logic [3:0]         cls;
    logic               is_alu, is_ls, is_st, stop, found;
    int                 idx;
    int                 start;

`ifdef ALLOC_RR_EN
    localparam int PTR_W = (ALU_CNT > 1) ? $clog2(ALU_CNT) : 1;
    logic [PTR_W-1:0] rr_ptr;
    logic             any_alu;
    int               last_alu;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= '0;
        else if (rdy && any_alu)
            rr_ptr <= PTR_W'((last_alu + 1) % ALU_CNT);
    end

    assign start = int'(rr_ptr);
`else
    assign start = 0;
`endif

    always_comb begin
        for (int k = 0; k < ALU_CNT; k++)
            alu_free[k] = !alu_valid[k] || alu_ready[k];
        ls_free = !ls_valid || ls_ready;
    end

    // Slots are walked in order; the first slot that cannot be placed sets
    // stop, which keeps in_ready a prefix mask.
    always_comb begin
        stop      = !rdy || flush;
        alu_claim = '0;
        ls_claim  = 1'b0;
        ls_src    = 0;
        acc       = '0;
        wr        = '0;
        cls       = '0;
        is_alu    = 1'b0;
        is_ls     = 1'b0;
        is_st     = 1'b0;
        found     = 1'b0;
        idx       = 0;
`ifdef ALLOC_RR_EN
        any_alu   = 1'b0;
        last_alu  = 0;
`endif
        for (int k = 0; k < ALU_CNT; k++)
            alu_src[k] = 0;
        for (int j = 0; j < DISP_W; j++) begin
            own_tag[j] = '0;
            cls    = in_op[j*8+4 +: 4];
            is_alu = in_valid[j] && (cls == 4'b0001 || cls == 4'b0010 || cls == 4'b0101);
            is_st  = in_valid[j] && (cls == 4'b0011);
            is_ls  = is_st || (in_valid[j] && cls == 4'b1001);
            if (!stop) begin
                if (is_alu) begin
                    found = 1'b0;
                    for (int n = 0; n < ALU_CNT; n++) begin
                        idx = (start + n) % ALU_CNT;
                        if (!found && alu_free[idx] && !alu_claim[idx]) begin
                            found          = 1'b1;
                            alu_claim[idx] = 1'b1;
                            alu_src[idx]   = j;
                            own_tag[j]     = TAG_W'(idx + 1);
`ifdef ALLOC_RR_EN
                            any_alu        = 1'b1;
                            last_alu       = idx;
`endif
                        end
                    end
                    acc[j] = found;
                    stop   = !found;
                end else if (is_ls) begin
                    if (ls_free && !ls_claim) begin
                        ls_claim   = 1'b1;
                        ls_src     = j;
                        own_tag[j] = TAG_W'(ALU_CNT + 1);
                        acc[j]     = 1'b1;
                    end else begin
                        stop = 1'b1;
                    end
                end else begin
                    acc[j] = 1'b1;
                end
            end
            wr[j] = acc[j] && (is_alu || (is_ls && !is_st)) && in_en_w[j]
                    && (in_addrw[j*5 +: 5] != 5'd0);

            // Later writers overwrite earlier ones, so the highest earlier
            // accepted writer of the address wins.
            s_tagx[j] = in_tagx[j*TAG_W +: TAG_W];
            s_tagy[j] = in_tagy[j*TAG_W +: TAG_W];
            for (int i = 0; i < j; i++) begin
                if (wr[i] && in_addrx[j*5 +: 5] != 5'd0 && in_addrw[i*5 +: 5] == in_addrx[j*5 +: 5])
                    s_tagx[j] = own_tag[i];
                if (wr[i] && in_addry[j*5 +: 5] != 5'd0 && in_addrw[i*5 +: 5] == in_addry[j*5 +: 5])
                    s_tagy[j] = own_tag[i];
            end
            if (!in_en_ry[j])
                s_tagy[j] = '0;
            s_datay[j] = in_en_ry[j] ? in_datay[j*WORD_W +: WORD_W] : '0;
            s_tagw[j]  = wr[j] ? own_tag[j] : '0;
            s_addrw[j] = wr[j] ? in_addrw[j*5 +: 5] : 5'd0;
        end
    end

    assign in_ready = acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_valid <= '0;
            alu_op    <= '0;
            alu_pc    <= '0;
            alu_tagx  <= '0;
            alu_tagy  <= '0;
            alu_tagw  <= '0;
            alu_datax <= '0;
            alu_datay <= '0;
            alu_addrw <= '0;
            ls_valid  <= 1'b0;
            ls_op     <= '0;
            ls_pc     <= '0;
            ls_tagx   <= '0;
            ls_tagy   <= '0;
            ls_tagw   <= '0;
            ls_datax  <= '0;
            ls_datay  <= '0;
            ls_addrw  <= '0;
            mw_en     <= '0;
            mw_addr   <= '0;
            mw_tag    <= '0;
        end else if (rdy) begin
            for (int k = 0; k < ALU_CNT; k++) begin
                if (alu_claim[k]) begin
                    alu_valid[k]                 <= 1'b1;
                    alu_op[k*4 +: 4]             <= in_op[alu_src[k]*8 +: 4];
                    alu_pc[k*WORD_W +: WORD_W]   <= in_pc[alu_src[k]*WORD_W +: WORD_W];
                    alu_tagx[k*TAG_W +: TAG_W]   <= s_tagx[alu_src[k]];
                    alu_tagy[k*TAG_W +: TAG_W]   <= s_tagy[alu_src[k]];
                    alu_tagw[k*TAG_W +: TAG_W]   <= s_tagw[alu_src[k]];
                    alu_datax[k*WORD_W +: WORD_W] <= in_datax[alu_src[k]*WORD_W +: WORD_W];
                    alu_datay[k*WORD_W +: WORD_W] <= s_datay[alu_src[k]];
                    alu_addrw[k*5 +: 5]          <= s_addrw[alu_src[k]];
                end else if (flush || alu_ready[k]) begin
                    alu_valid[k] <= 1'b0;
                end
            end
            if (ls_claim) begin
                ls_valid <= 1'b1;
                ls_op    <= in_op[ls_src*8 +: 4];
                ls_pc    <= in_pc[ls_src*WORD_W +: WORD_W];
                ls_tagx  <= s_tagx[ls_src];
                ls_tagy  <= s_tagy[ls_src];
                ls_tagw  <= s_tagw[ls_src];
                ls_datax <= in_datax[ls_src*WORD_W +: WORD_W];
                ls_datay <= s_datay[ls_src];
                ls_addrw <= s_addrw[ls_src];
            end else if (flush || ls_ready) begin
                ls_valid <= 1'b0;
            end
            for (int j = 0; j < DISP_W; j++) begin
                mw_en[j]                  <= wr[j];
                mw_addr[j*5 +: 5]         <= s_addrw[j];
                mw_tag[j*TAG_W +: TAG_W]  <= s_tagw[j];
            end
        end
    end

endmodule

// File: doc/dispatch_allocator.md
# dispatch_allocator

- Parametrised in-order dispatch stage between the decoder/register-status read and the execution units.
- Accepts up to `DISP_W` decoded instructions per cycle and steers each to one of `ALU_CNT` ALU issue registers or the single load/store issue register.
- Renames destination registers to the owning unit tag and corrects intra-group RAW tags.
- Holds every issue register under a valid/ready handshake until its unit takes it.

## Interface
Parameters:
- `DISP_W`, 2: instruction slots per cycle (1–4).
- `ALU_CNT`, 2: ALU issue registers (1–4).
- `TAG_W`, 3: tag width; 0 = UNLOCKED; ALU k owns tag k+1; LS owns tag ALU_CNT+1.
- `WORD_W`, 32: data and pc width.

Ports (vectors are slot- or unit-concatenated, slot/unit 0 in the LSBs):
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rdy` in 1: global enable; when low, no state changes.
- `flush` in 1: drop all issue registers and refuse input this cycle.
- `in_valid` in DISP_W: slot holds an instruction.
- `in_op` in 8·DISP_W: opcode; `[7:4]` class, `[3:0]` sub-op.
- `in_pc` in WORD_W·DISP_W: instruction pc.
- `in_en_ry`, `in_en_w` in DISP_W each: y operand used; destination written.
- `in_addrx`, `in_addry`, `in_addrw` in 5·DISP_W each: register addresses.
- `in_tagx`, `in_tagy` in TAG_W·DISP_W each: register-status tags.
- `in_datax`, `in_datay` in WORD_W·DISP_W each: register-file data.
- `in_ready` out DISP_W: combinational; a prefix mask of slots accepted this cycle.
- `alu_valid` out ALU_CNT, `alu_ready` in ALU_CNT: ALU handshake.
- `alu_op` out 4·ALU_CNT; `alu_pc` out WORD_W·ALU_CNT.
- `alu_tagx`, `alu_tagy`, `alu_tagw` out TAG_W·ALU_CNT each.
- `alu_datax`, `alu_datay` out WORD_W·ALU_CNT each; `alu_addrw` out 5·ALU_CNT.
- `ls_valid` out 1, `ls_ready` in 1: LS handshake.
- `ls_op`, `ls_pc`, `ls_tagx`, `ls_tagy`, `ls_tagw`, `ls_datax`, `ls_datay`, `ls_addrw`: out; same widths as one ALU lane.
- `mw_en` out DISP_W, `mw_addr` out 5·DISP_W, `mw_tag` out TAG_W·DISP_W: registered register-status update, one lane per slot.

## Operation
- Class decode on `op[7:4]`:
  - 0001/0010/0101 = ALU.
  - 0011 = store (LS, never writes).
  - 1001 = load (LS, writes).
  - Anything else, or `in_valid` low = NOP; a NOP consumes its slot without using a unit.
- An issue register is free when `!valid`, or when `valid && ready` this cycle (pass-through refill).
- Slots are scanned in order 0..DISP_W-1:
  - ALU slots claim the lowest-index free ALU not already claimed this cycle.
  - Load/store slots claim LS if it is free and unclaimed.
  - The first slot that cannot be placed stops acceptance of it and all later slots.
- Destination write happens only when `en_w && addrw!=0` (store never writes).
  - Such a slot drives `mw_en` with `mw_tag` = its claimed unit tag.
- Intra-group bypass: slot j's x/y tag is replaced by the tag of the highest earlier accepted slot in the group that writes the same non-zero address.
  - `tagy` = 0 and `datay` = 0 when `!en_ry`.
- Issue register update:
  - Claimed register loads the slot fields and sets valid.
  - Otherwise valid clears on `ready`; fields hold while valid.
- `flush` clears all valid bits and `mw_en`, and forces `in_ready` = 0, overriding acceptance in the same cycle.
- Reset: all valid = 0, `mw_en` = 0, all payload/tag/addr outputs = 0; round-robin pointer = 0.

## Timing
- Accept at edge N → `*_valid` and `mw_en` high after edge N (one-cycle latency).
- `mw_*` is a one-cycle pulse.
- `in_ready` depends combinationally on `in_*`, `*_ready` and `flush`; no other output is combinational.
- When `rdy` is low, all registers hold and `in_ready` = 0.
- Unit back-pressure: a valid register with `ready` low holds bit-exact.
- `rst` asserted mid-operation clears state immediately; the first accept is possible on the first edge after deassertion.

## Configuration
- `ALLOC_RR_EN` defined:
  - ALU choice starts at a round-robin pointer and proceeds upward with wrap.
  - The pointer advances to one past the last ALU claimed in the cycle, and holds if none was claimed.
- Undefined: fixed lowest-index-first priority; no pointer register.

## Test plan
- Reset with ALU_CNT=2, DISP_W=2 → all valid 0, `mw_en` 0, `in_ready` reflects free units.
- Two ALU ops, slot0 writes x5, slot1 reads x5 (in_tagx=0) → `alu_valid`=2'b11; ALU1 `tagx`=1; `mw_tag`={2,1}, `mw_en`=2'b11.
- Load + store in one group, LS free → `in_ready`=2'b01, load in LS with `ls_tagw`=3, `mw_en`=2'b01; store accepted the next cycle.
- ALU0 valid with `alu_ready`=0, ALU1 busy, one ALU op → `in_ready`=0, ALU0 fields unchanged over 3 cycles; `alu_ready`=1 → accepted same cycle.
- `flush` with both ALUs and LS valid and new input → all valid 0 next edge, `in_ready`=0, `mw_en`=0.
- `ALLOC_RR_EN`, single ALU op per cycle for 4 cycles, all units ready → ALU index sequence 0,1,0,1; without macro 0,0,0,0.
